// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours:
// opcode/NOP constants, the fetch FSM state type and the IF/ID register layout.
package if_fetch_unit_pkg;

  localparam logic [6:0]  OP_BRANCH        = 7'b1100011;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    REDIR = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc: 32'h0, valid: 1'b0};

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == OP_BRANCH;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch stage's I-cache, predictor and IF/ID signals.
// The master side is the fetch unit; the slave side is its environment.
interface if_fetch_unit_if;

  logic        ic_ren;
  logic [29:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_stall;
  logic        stall;
  logic [31:0] PC_out;
  logic        correct;
  logic        branch_IF;
  logic [31:0] PC_add_4;
  logic [31:0] PC_add_imm;
  logic        fetch_stall;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;

  modport master (
    output ic_ren, ic_addr, branch_IF, PC_add_4, PC_add_imm, fetch_stall,
           instr_ID, pc_ID, valid_ID,
    input  ic_rdata, ic_stall, stall, PC_out, correct
  );

  modport slave (
    input  ic_ren, ic_addr, branch_IF, PC_add_4, PC_add_imm, fetch_stall,
           instr_ID, pc_ID, valid_ID,
    output ic_rdata, ic_stall, stall, PC_out, correct
  );

endinterface

// File: rtl/if_fetch_unit_imm_b_gen.sv
// Combinational B-type immediate extractor; shared with the decode stage.
module imm_b_gen (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  assign imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  // rs1/rs2/funct3 and opcode fields carry no immediate bits.
  logic unused_bits;
  assign unused_bits = &{1'b0, instr_i[24:12], instr_i[6:0]};

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache read port, feeds the
// branch predictor and loads IF/ID, squashing wrong-path words on a mispredict.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  redir_pc_q;
  ifid_t        ifid_q;
  logic         ic_ren_q;
  logic [31:0]  imm_b;

  imm_b_gen u_imm_b_gen (
    .instr_i (bus.ic_rdata),
    .imm_o   (imm_b)
  );

  assign bus.ic_ren      = ic_ren_q;
  assign bus.ic_addr     = pc_q[31:2];
  assign bus.PC_add_4    = pc_q + 32'd4;
  assign bus.PC_add_imm  = pc_q + imm_b;
  assign bus.fetch_stall = bus.ic_stall | (state_q == REDIR);
  assign bus.branch_IF   = ((state_q == RUN) || (state_q == MISS)) && !bus.ic_stall &&
                           bus.correct && is_branch(bus.ic_rdata[6:0]);
  assign bus.instr_ID    = ifid_q.instr;
  assign bus.pc_ID       = ifid_q.pc;
  assign bus.valid_ID    = ifid_q.valid;

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every branch reads the pre-edge values of the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redir_pc_q <= 32'h0;
      ifid_q     <= IFID_BUBBLE;
      ic_ren_q   <= 1'b0;
    end else begin
      // BOOT is only ever entered through reset, so the read port stays on.
      ic_ren_q <= 1'b1;

      if (!bus.correct) begin
        // The word in IF is wrong-path regardless of stalls.
        ifid_q <= IFID_BUBBLE;
        if (bus.ic_stall) begin
          redir_pc_q <= bus.PC_out;
          state_q    <= REDIR;
        end else begin
          pc_q    <= bus.PC_out;
          state_q <= RUN;
        end
      end else begin
        unique case (state_q)
          BOOT: state_q <= RUN;

          RUN, MISS: begin
            if (bus.ic_stall) begin
              state_q <= MISS;
              if (!bus.stall) ifid_q <= IFID_BUBBLE;
            end else begin
              state_q <= RUN;
              if (!bus.stall) begin
                pc_q   <= bus.PC_out;
                ifid_q <= '{instr: bus.ic_rdata, pc: pc_q, valid: 1'b1};
              end
            end
          end

          REDIR: begin
            // The returning miss word belongs to the squashed path.
            if (!bus.ic_stall) begin
              pc_q    <= redir_pc_q;
              ifid_q  <= IFID_BUBBLE;
              state_q <= RUN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_checks;
  int   n_errors;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a booted flag, a pending-redirect flag with its target,
  // the PC and the IF/ID contents.
  logic        m_booted;
  logic        m_pending;
  logic [31:0] m_target;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic        m_valid;

  function automatic logic [31:0] b_imm(input logic [31:0] i);
    int v;
    v = 0;
    v += int'((i >> 8) & 32'hF) * 2;
    v += int'((i >> 25) & 32'h3F) * 32;
    v += int'((i >> 7) & 32'h1) * 2048;
    if (i[31]) v -= 4096;
    return 32'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_booted  <= 1'b0;
      m_pending <= 1'b0;
      m_target  <= 32'h0;
      m_pc      <= 32'h0;
      m_instr   <= NOP_W;
      m_pcid    <= 32'h0;
      m_valid   <= 1'b0;
    end else begin
      m_booted <= 1'b1;
      if (!bus.correct) begin
        m_instr <= NOP_W; m_pcid <= 32'h0; m_valid <= 1'b0;
        if (bus.ic_stall) begin
          m_pending <= 1'b1;
          m_target  <= bus.PC_out;
        end else begin
          m_pending <= 1'b0;
          m_pc      <= bus.PC_out;
        end
      end else if (!m_booted) begin
        // first cycle after reset only powers up the read port
      end else if (m_pending) begin
        if (!bus.ic_stall) begin
          m_pending <= 1'b0;
          m_pc      <= m_target;
          m_instr <= NOP_W; m_pcid <= 32'h0; m_valid <= 1'b0;
        end
      end else if (bus.ic_stall) begin
        if (!bus.stall) begin
          m_instr <= NOP_W; m_pcid <= 32'h0; m_valid <= 1'b0;
        end
      end else if (!bus.stall) begin
        m_instr <= bus.ic_rdata;
        m_pcid  <= m_pc;
        m_valid <= 1'b1;
        m_pc    <= bus.PC_out;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ic_ren",      {31'b0, bus.ic_ren},      {31'b0, m_booted});
      check("ic_addr",     {2'b0, bus.ic_addr},      m_pc >> 2);
      check("fetch_stall", {31'b0, bus.fetch_stall}, {31'b0, bus.ic_stall | m_pending});
      check("branch_IF",   {31'b0, bus.branch_IF},
            {31'b0, m_booted && !m_pending && !bus.ic_stall && bus.correct &&
                    (bus.ic_rdata[6:0] == 7'h63)});
      check("PC_add_4",    bus.PC_add_4,   m_pc + 32'd4);
      check("PC_add_imm",  bus.PC_add_imm, m_pc + b_imm(bus.ic_rdata));
      check("instr_ID",    bus.instr_ID,   m_instr);
      check("pc_ID",       bus.pc_ID,      m_pcid);
      check("valid_ID",    {31'b0, bus.valid_ID}, {31'b0, m_valid});
    end
  end

  task automatic drive(input logic ics, input logic st, input logic cor,
                       input logic [31:0] pco, input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus.ic_stall = ics;
    bus.stall    = st;
    bus.correct  = cor;
    bus.PC_out   = pco;
    bus.ic_rdata = rd;
    #1;
  endtask

  localparam logic [31:0] W0  = 32'h0010_0093, W1 = 32'h0020_0113, W2 = 32'h0030_0193;
  localparam logic [31:0] W3  = 32'h0040_0213, W4 = 32'h0050_0293, W5 = 32'h0060_0313;
  localparam logic [31:0] W6  = 32'h0070_0393, W8 = 32'h0090_0493, W9 = 32'h00a0_0513;
  localparam logic [31:0] BEQ = 32'h0080_0463, BNEG = 32'hFE00_0EE3;

  initial begin
    logic        r_ics, r_st, r_cor;
    logic [31:0] r_pco, r_rd;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    rst      = 1'b0;
    bus.ic_stall = 1'b0; bus.stall = 1'b0; bus.correct = 1'b1;
    bus.PC_out   = 32'h0; bus.ic_rdata = NOP_W;
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst ic_ren",   {31'b0, bus.ic_ren}, 32'd0);
    check("rst ic_addr",  {2'b0, bus.ic_addr}, 32'd0);
    check("rst instr_ID", bus.instr_ID, NOP_W);
    check("rst pc_ID",    bus.pc_ID, 32'd0);
    check("rst valid_ID", {31'b0, bus.valid_ID}, 32'd0);

    // Straight-line hits from 0.
    drive(0, 0, 1, 32'h4, W0); rst = 1'b0; #1;
    check("boot ic_ren",  {31'b0, bus.ic_ren}, 32'd0);
    drive(0, 0, 1, 32'h4, W0);
    check("run ic_ren",   {31'b0, bus.ic_ren}, 32'd1);
    check("addr0",        {2'b0, bus.ic_addr}, 32'd0);
    check("valid0",       {31'b0, bus.valid_ID}, 32'd0);
    drive(0, 0, 1, 32'h8, W1);
    check("addr1",        {2'b0, bus.ic_addr}, 32'd1);
    check("pc_ID0",       bus.pc_ID, 32'h0);
    check("instr_ID0",    bus.instr_ID, W0);
    check("valid1",       {31'b0, bus.valid_ID}, 32'd1);
    drive(0, 0, 1, 32'hC, W2);
    check("addr2",        {2'b0, bus.ic_addr}, 32'd2);
    check("pc_ID4",       bus.pc_ID, 32'h4);
    drive(0, 0, 1, 32'h10, W3);
    check("pc_ID8",       bus.pc_ID, 32'h8);

    // Branch at 0x10, then mispredict to 0x40.
    drive(0, 0, 1, 32'h18, BEQ);
    check("beq addr",     {2'b0, bus.ic_addr}, 32'd4);
    check("beq branch",   {31'b0, bus.branch_IF}, 32'd1);
    check("beq add_imm",  bus.PC_add_imm, 32'h18);
    check("beq add_4",    bus.PC_add_4, 32'h14);
    drive(0, 0, 0, 32'h40, BEQ);
    check("mp branch",    {31'b0, bus.branch_IF}, 32'd0);
    check("mp pc_ID",     bus.pc_ID, 32'h10);
    drive(0, 0, 1, 32'h20, W4);
    check("mp bubble",    bus.instr_ID, NOP_W);
    check("mp valid",     {31'b0, bus.valid_ID}, 32'd0);
    check("mp addr",      {2'b0, bus.ic_addr}, 32'h10);

    // Three-cycle miss at 0x20.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 32'h24, W5);
      check("miss fstall", {31'b0, bus.fetch_stall}, 32'd1);
      check("miss addr",   {2'b0, bus.ic_addr}, 32'h8);
    end
    drive(0, 0, 1, 32'h24, W5);
    check("miss done fstall", {31'b0, bus.fetch_stall}, 32'd0);
    drive(0, 0, 1, 32'h28, W6);
    check("miss instr",   bus.instr_ID, W5);
    check("miss pc_ID",   bus.pc_ID, 32'h20);

    // Miss, mispredict to 0x80, overridden by 0x90.
    drive(1, 0, 1, 32'h2C, W6);
    drive(1, 0, 0, 32'h80, W6);
    drive(1, 0, 1, 32'h2C, W6);
    check("redir fstall", {31'b0, bus.fetch_stall}, 32'd1);
    check("redir addr",   {2'b0, bus.ic_addr}, 32'hA);
    drive(1, 0, 0, 32'h90, W6);
    drive(0, 0, 1, 32'h100, BEQ);
    check("redir fstall2", {31'b0, bus.fetch_stall}, 32'd1);
    check("redir branch",  {31'b0, bus.branch_IF}, 32'd0);
    drive(0, 0, 1, 32'h94, W8);
    check("redir addr2",   {2'b0, bus.ic_addr}, 32'h24);
    check("redir bubble",  bus.instr_ID, NOP_W);
    check("redir valid",   {31'b0, bus.valid_ID}, 32'd0);

    // Stall freezes PC and IF/ID.
    drive(0, 1, 1, 32'h200, W9);
    check("stall instr",  bus.instr_ID, W8);
    check("stall pc_ID",  bus.pc_ID, 32'h90);
    drive(0, 1, 1, 32'h200, W9);
    check("stall addr",   {2'b0, bus.ic_addr}, 32'h25);
    check("stall instr2", bus.instr_ID, W8);

    // Reset in the middle of a miss.
    drive(1, 0, 1, 32'h98, W9);
    drive(1, 0, 1, 32'h98, W9);
    rst = 1'b1; #1;
    check("mrst ic_ren",  {31'b0, bus.ic_ren}, 32'd0);
    check("mrst addr",    {2'b0, bus.ic_addr}, 32'd0);
    check("mrst instr",   bus.instr_ID, NOP_W);
    check("mrst pc_ID",   bus.pc_ID, 32'd0);
    check("mrst valid",   {31'b0, bus.valid_ID}, 32'd0);

    // Wrap-around arithmetic at the top of the address space.
    drive(0, 0, 1, 32'hFFFF_FFFC, W0); rst = 1'b0; #1;
    check("boot2 ic_ren", {31'b0, bus.ic_ren}, 32'd0);
    drive(0, 0, 1, 32'hFFFF_FFFC, W0);
    drive(0, 0, 1, 32'h0, BNEG);
    check("wrap add_4",   bus.PC_add_4, 32'h0);
    check("wrap add_imm", bus.PC_add_imm, 32'hFFFF_FFF8);
    check("wrap branch",  {31'b0, bus.branch_IF}, 32'd1);
    check("wrap addr",    {2'b0, bus.ic_addr}, 32'h3FFF_FFFF);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r_ics = ($urandom_range(0, 99) < 25);
      r_st  = ($urandom_range(0, 99) < 20);
      r_cor = ($urandom_range(0, 99) >= 10);
      case ($urandom_range(0, 9))
        0, 1:    r_pco = $urandom & 32'h0000_0FFC;
        2:       r_pco = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: r_pco = m_pc + 32'd4;
      endcase
      r_rd = $urandom;
      if ($urandom_range(0, 9) < 3) r_rd[6:0] = 7'h63;
      drive(r_ics, r_st, r_cor, r_pco, r_rd);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    drive(0, 0, 1, 32'h0, NOP_W);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
